// File: rtl/cpu_bus_pkg.sv
// Shared types for the SRAM-like CPU bus.
//   req_id_t       : requester tag carried through the arbiter (ID_INST / ID_DATA)
//   sramlike_req_t : request payload {wr, size, addr, wdata} as seen on one port
package cpu_bus_pkg;

    typedef logic req_id_t;

    localparam req_id_t ID_INST = 1'b0;
    localparam req_id_t ID_DATA = 1'b1;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sramlike_req_t;

endpackage

// File: rtl/id_fifo.sv
// Small in-order tag FIFO recording which requester owns each accepted
// transaction.
//   clk, rst   : clock, synchronous active-high reset (pointers/count only)
//   push, din  : write one tag
//   pop, dout  : dout is the head tag; pop removes it
//   full/empty : occupancy flags, count : number of stored tags
// Push and pop in the same cycle are allowed; the caller never pushes when
// full and never pops when empty.
module id_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_p0;
    logic [PTR_W-1:0] rd_ptr_p0;
    logic [CNT_W-1:0] count_p0;

    // Wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    // ---- control registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
            count_p0  <= '0;
        end else begin
            if (push) wr_ptr_p0 <= next_ptr(wr_ptr_p0);
            if (pop)  rd_ptr_p0 <= next_ptr(rd_ptr_p0);
            case ({push, pop})
                2'b10:   count_p0 <= count_p0 + 1'b1;
                2'b01:   count_p0 <= count_p0 - 1'b1;
                default: count_p0 <= count_p0;
            endcase
        end
    end

    // ---- storage (no reset, contents are only read while counted) ----
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_p0] <= din;
    end

    assign dout  = mem_q[rd_ptr_p0];
    assign count = count_p0;
    assign full  = (count_p0 == CNT_W'(DEPTH));
    assign empty = (count_p0 == '0);

endmodule

// File: rtl/sramlike_arbiter_2x1.sv
// Two-to-one arbiter sharing one SRAM-like master port between the
// instruction requester (inst_*) and the data requester (data_*).
//   clk, rst          : clock, synchronous active-high reset
//   inst_*/data_*     : requester ports (req/wr/size/addr/wdata in,
//                       rdata/addr_ok/data_ok out)
//   mem_*             : downstream master port
//   busy              : transactions outstanding or a grant is held
//   err_spurious      : sticky, a response arrived with nothing outstanding
// Data has priority except after STARVE_LIMIT consecutive data accepts
// while inst waits. A grant that is not accepted in its first cycle is
// locked until accepted. Accepted tags are kept in order so each data_ok
// is steered to the requester that issued it.
module sramlike_arbiter_2x1
    import cpu_bus_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    output logic        busy,
    output logic        err_spurious
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic             locked_p0;
    req_id_t          lock_id_p0;
    logic [STV_W-1:0] starve_cnt_p0;
    logic             err_p0;

    req_id_t          owner;
    logic             grant_vld;
    logic             owner_req;
    logic             accept;
    logic             pop;
    logic             spurious;

    logic             fifo_full;
    logic             fifo_empty;
    req_id_t          fifo_head;
    logic [CNT_W-1:0] fifo_count;

    sramlike_req_t    inst_pl;
    sramlike_req_t    data_pl;
    sramlike_req_t    mem_pl;

    // ---- state registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_p0     <= 1'b0;
            lock_id_p0    <= ID_INST;
            starve_cnt_p0 <= '0;
            err_p0        <= 1'b0;
        end else begin
            // A request left hanging keeps its grant; acceptance releases it.
            locked_p0 <= mem_req & ~mem_addr_ok;
            if (mem_req & ~mem_addr_ok) lock_id_p0 <= owner;

            if (!inst_req || inst_addr_ok)
                starve_cnt_p0 <= '0;
            else if (data_addr_ok && starve_cnt_p0 != STV_W'(STARVE_LIMIT))
                starve_cnt_p0 <= starve_cnt_p0 + 1'b1;

            if (spurious) err_p0 <= 1'b1;
        end
    end

    // ---- grant selection ----
    always_comb begin
        owner     = ID_INST;
        grant_vld = 1'b0;
        if (locked_p0) begin
            // A locked grant bypasses the full check; it was taken while not full.
            owner     = lock_id_p0;
            grant_vld = 1'b1;
        end else if (fifo_full) begin
            grant_vld = 1'b0;
        end else if (data_req && !(inst_req && starve_cnt_p0 == STV_W'(STARVE_LIMIT))) begin
            owner     = ID_DATA;
            grant_vld = 1'b1;
        end else if (inst_req) begin
            owner     = ID_INST;
            grant_vld = 1'b1;
        end
    end

    // ---- output mux and response routing ----
    assign inst_pl   = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
    assign data_pl   = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
    assign mem_pl    = (owner == ID_DATA) ? data_pl : inst_pl;
    assign owner_req = (owner == ID_DATA) ? data_req : inst_req;

    assign mem_req   = grant_vld & owner_req;
    assign mem_wr    = mem_pl.wr;
    assign mem_size  = mem_pl.size;
    assign mem_addr  = mem_pl.addr;
    assign mem_wdata = mem_pl.wdata;

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & (owner == ID_INST);
    assign data_addr_ok = accept & (owner == ID_DATA);

    assign pop          = mem_data_ok & ~fifo_empty;
    assign spurious     = mem_data_ok & fifo_empty;
    assign inst_data_ok = pop & (fifo_head == ID_INST);
    assign data_data_ok = pop & (fifo_head == ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign busy         = (fifo_count != '0) | locked_p0;
    assign err_spurious = err_p0;

    id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (1)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (owner),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_sramlike_arbiter_2x1.sv
module tb_sramlike_arbiter_2x1;

    logic        clk;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_addr_ok, mem_data_ok;
    logic        busy, err_spurious;

    typedef struct {
        logic        id;
        logic [31:0] val;
    } exp_t;

    exp_t exp_acc[$];
    exp_t exp_rsp[$];

    int total;
    int bad;

    sramlike_arbiter_2x1 #(
        .MAX_OUTSTANDING (2),
        .STARVE_LIMIT    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .busy         (busy),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inst side reads with size 1, data side writes with size 2; wdata is ~addr
    // so the payload mux can be checked against the address.
    task automatic drv(input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic [31:0] daddr,
                       input logic aok, input logic dok, input logic [31:0] rdata);
        inst_req    = ireq;
        inst_wr     = 1'b0;
        inst_size   = 2'd1;
        inst_addr   = iaddr;
        inst_wdata  = ~iaddr;
        data_req    = dreq;
        data_wr     = 1'b1;
        data_size   = 2'd2;
        data_addr   = daddr;
        data_wdata  = ~daddr;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rdata;
    endtask

    task automatic exp_accept(input logic id, input logic [31:0] addr);
        exp_t e;
        e.id  = id;
        e.val = addr;
        exp_acc.push_back(e);
    endtask

    task automatic exp_return(input logic id, input logic [31:0] rdata);
        exp_t e;
        e.id  = id;
        e.val = rdata;
        exp_rsp.push_back(e);
    endtask

    // Scoreboard monitor: checks every accept and every response the DUT shows.
    always @(negedge clk) begin
        exp_t e;
        if (inst_data_ok || data_data_ok) begin
            if (exp_rsp.size() == 0) begin
                chk("rsp_unexpected", {30'b0, inst_data_ok, data_data_ok}, 32'h0);
            end else begin
                e = exp_rsp.pop_front();
                chk("rsp_onehot", {31'b0, inst_data_ok & data_data_ok}, 32'h0);
                chk("rsp_id", {31'b0, data_data_ok}, {31'b0, e.id});
                chk("rsp_rdata", data_data_ok ? data_rdata : inst_rdata, e.val);
            end
        end
        if (mem_req && mem_addr_ok) begin
            if (exp_acc.size() == 0) begin
                chk("acc_unexpected", mem_addr, 32'h0);
            end else begin
                e = exp_acc.pop_front();
                chk("acc_onehot", {31'b0, inst_addr_ok ^ data_addr_ok}, 32'h1);
                chk("acc_id", {31'b0, data_addr_ok}, {31'b0, e.id});
                chk("acc_addr", mem_addr, e.val);
                chk("acc_wdata", mem_wdata, ~e.val);
                chk("acc_wr", {31'b0, mem_wr}, {31'b0, e.id});
                chk("acc_size", {30'b0, mem_size}, e.id ? 32'd2 : 32'd1);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_mem_req", {31'b0, mem_req}, 0);
        chk("rst_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 0);
        chk("rst_data_ok", {30'b0, inst_data_ok, data_data_ok}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_err", {31'b0, err_spurious}, 0);
        tick();
        rst = 1'b0;

        // Single inst read, response three cycles after accept
        drv(1, 32'h0000_1000, 0, 0, 1, 0, 0);
        exp_accept(0, 32'h0000_1000);
        exp_return(0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t1_mem_req", {31'b0, mem_req}, 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t1_busy_out", {31'b0, busy}, 1);
        tick();
        tick();
        drv(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t1_busy_idle", {31'b0, busy}, 0);

        // Both request; data wins and its grant holds through two wait cycles
        tick();
        drv(1, 32'h0000_2000, 1, 32'h0000_3000, 0, 0, 0);
        @(negedge clk);
        chk("t2_mem_req", {31'b0, mem_req}, 1);
        chk("t2_data_first", mem_addr, 32'h0000_3000);
        tick();
        @(negedge clk);
        chk("t2_lock_addr", mem_addr, 32'h0000_3000);
        chk("t2_lock_busy", {31'b0, busy}, 1);
        tick();
        drv(1, 32'h0000_2000, 1, 32'h0000_3000, 1, 0, 0);
        exp_accept(1, 32'h0000_3000);
        exp_return(1, 32'hAAAA_0001);
        tick();
        drv(1, 32'h0000_2000, 0, 0, 1, 0, 0);
        exp_accept(0, 32'h0000_2000);
        exp_return(0, 32'hBBBB_0002);
        @(negedge clk);
        chk("t2_inst_next", mem_addr, 32'h0000_2000);

        // Two outstanding: new grant blocked, also in the cycle a response pops
        tick();
        drv(1, 32'h0000_4000, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("full_blocks", {31'b0, mem_req}, 0);
        tick();
        drv(1, 32'h0000_4000, 0, 0, 1, 1, 32'hAAAA_0001);
        @(negedge clk);
        chk("full_pop_blocks", {31'b0, mem_req}, 0);
        tick();
        drv(1, 32'h0000_4000, 0, 0, 1, 0, 0);
        exp_accept(0, 32'h0000_4000);
        exp_return(0, 32'hCCCC_0003);
        @(negedge clk);
        chk("full_release", {31'b0, mem_req}, 1);
        tick();
        drv(0, 0, 0, 0, 0, 1, 32'hBBBB_0002);
        tick();
        drv(0, 0, 0, 0, 0, 1, 32'hCCCC_0003);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_busy_idle", {31'b0, busy}, 0);

        // Starvation: pattern D D D D I repeating, each answered next cycle
        for (int k = 0; k <= 10; k++) begin
            tick();
            drv(k < 10, 32'h0000_6000, k < 10, 32'h0000_7000, 1, k > 0, 32'h5000_0000 + k);
            if (k < 10) begin
                if (k % 5 == 4) begin
                    exp_accept(0, 32'h0000_6000);
                    exp_return(0, 32'h5000_0000 + k + 1);
                end else begin
                    exp_accept(1, 32'h0000_7000);
                    exp_return(1, 32'h5000_0000 + k + 1);
                end
            end
        end
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("starve_busy_idle", {31'b0, busy}, 0);
        chk("starve_no_err", {31'b0, err_spurious}, 0);

        // Response with nothing outstanding
        tick();
        drv(0, 0, 0, 0, 0, 1, 32'h1234_5678);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("spurious_err", {31'b0, err_spurious}, 1);

        // Reset with two outstanding, then a stale response arrives
        tick();
        drv(0, 0, 1, 32'h0000_8000, 1, 0, 0);
        exp_accept(1, 32'h0000_8000);
        tick();
        drv(1, 32'h0000_9000, 0, 0, 1, 0, 0);
        exp_accept(0, 32'h0000_9000);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", {31'b0, busy}, 0);
        chk("post_rst_err", {31'b0, err_spurious}, 0);
        chk("post_rst_mem_req", {31'b0, mem_req}, 0);
        tick();
        drv(0, 0, 0, 0, 0, 1, 32'h0BAD_0BAD);
        tick();
        drv(1, 32'h0000_A000, 0, 0, 1, 0, 0);
        exp_accept(0, 32'h0000_A000);
        exp_return(0, 32'hA0A0_A0A0);
        @(negedge clk);
        chk("stale_rsp_err", {31'b0, err_spurious}, 1);
        chk("count_cleared", {31'b0, mem_req}, 1);
        tick();
        drv(0, 0, 0, 0, 0, 1, 32'hA0A0_A0A0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("final_busy", {31'b0, busy}, 0);

        chk("acc_queue_drained", exp_acc.size(), 0);
        chk("rsp_queue_drained", exp_rsp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
